// File: rtl/ex_div_ctrl.sv
// rtl/ex_div_ctrl.sv - multi-cycle restoring divide sequencer for DIV/DIVU in EX
// Returns {remainder, quotient}; holds the result while EX keeps start_i high.
module ex_div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic        sgn_q;
  logic        dvd_neg_q;
  logic        dvs_neg_q;
  logic [63:0] result_q;
  logic        ready_q;
  logic        busy_q;

  logic [32:0] trial;
  logic [32:0] diff;
  logic        take;
  logic [31:0] rem_d;
  logic [31:0] quo_d;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic        dvd_neg_in;
  logic        dvs_neg_in;
  logic [31:0] dvd_abs;
  logic [31:0] dvs_abs;

  // Partial remainder stays below the divisor, so the borrow of trial-divisor decides each bit.
  always_comb begin
    trial      = {rem_q, quo_q[31]};
    diff       = trial - {1'b0, dvs_q};
    take       = ~diff[32];
    rem_d      = take ? diff[31:0] : trial[31:0];
    quo_d      = {quo_q[30:0], take};
    quo_fix    = (sgn_q & (dvd_neg_q ^ dvs_neg_q)) ? (~quo_d + 32'd1) : quo_d;
    rem_fix    = (sgn_q & dvd_neg_q) ? (~rem_d + 32'd1) : rem_d;
    dvd_neg_in = signed_i & opdata1_i[31];
    dvs_neg_in = signed_i & opdata2_i[31];
    dvd_abs    = dvd_neg_in ? (~opdata1_i + 32'd1) : opdata1_i;
    dvs_abs    = dvs_neg_in ? (~opdata2_i + 32'd1) : opdata2_i;
  end

  always_ff @(posedge clk) begin
    if (rst || annul_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvs_q     <= 32'd0;
      sgn_q     <= 1'b0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      result_q  <= 64'd0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            if (opdata2_i == 32'd0) begin
              state_q <= S_BYZERO;
            end else begin
              state_q   <= S_ON;
              quo_q     <= dvd_abs;
              dvs_q     <= dvs_abs;
              sgn_q     <= signed_i;
              dvd_neg_q <= dvd_neg_in;
              dvs_neg_q <= dvs_neg_in;
              rem_q     <= 32'd0;
              cnt_q     <= 6'd0;
            end
          end
        end
        S_BYZERO: begin
          state_q  <= S_END;
          ready_q  <= 1'b1;
          result_q <= 64'd0;
        end
        S_ON: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_q  <= S_END;
            ready_q  <= 1'b1;
            result_q <= {rem_fix, quo_fix};
          end
        end
        S_END: begin
          if (!start_i) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= 64'd0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign busy_o     = busy_q;
  assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb/tb_ex_div_ctrl.sv - directed and randomized checks of ex_div_ctrl
// Expected results come from 64-bit truncating arithmetic in ref_div.
module tb_ex_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;
  logic        stallreq_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_div_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .stallreq_o (stallreq_o)
  );

  function automatic logic [63:0] ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts an operation and waits for ready_o; operands are scrambled after acceptance.
  task automatic issue(input bit sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp_res, input int exp_lat);
    int lat;
    int stalls;
    @(negedge clk);
    signed_i  = sg;
    opdata1_i = a;
    opdata2_i = b;
    start_i   = 1'b1;
    #1;
    stalls = stallreq_o ? 1 : 0;
    lat    = 0;
    while (ready_o !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (stallreq_o) stalls++;
      if (lat == 1) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = 1'($urandom);
      end
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("stall_cycles", 64'(stalls), 64'(exp_lat));
    chk("result", result_o, exp_res);
    chk("busy_in_end", 64'(busy_o), 64'd1);
  endtask

  task automatic release_op(input int hold, input logic [63:0] exp_res);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_ready", 64'(ready_o), 64'd1);
      chk("hold_result", result_o, exp_res);
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_ready", 64'(ready_o), 64'd0);
    chk("drop_busy", 64'(busy_o), 64'd0);
    chk("drop_result", result_o, 64'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, 64'(ready_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_result"}, result_o, 64'd0);
  endtask

  initial begin
    logic [31:0] corners [6];
    logic [31:0] a, b;
    logic [63:0] exp;
    bit          sg;
    corners[0] = 32'h8000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h0000_0001;
    corners[3] = 32'h7FFF_FFFF;
    corners[4] = 32'h0000_0000;
    corners[5] = 32'hFFFF_FFFE;

    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0;
    opdata1_i = 32'd0; opdata2_i = 32'd0; annul_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    chk("reset_stall_idle", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    start_i = 1'b1; opdata2_i = 32'd3;
    #1;
    chk("reset_stall_comb", 64'(stallreq_o), 64'd1);
    @(posedge clk);
    #1;
    chk_idle_outputs("reset_held");
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;

    issue(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
    release_op(3, 64'h00000002_0000000E);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
    release_op(0, 64'hFFFFFFFF_FFFFFFFD);
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 33);
    release_op(0, 64'h00000001_FFFFFFFD);
    issue(1'b0, 32'd5, 32'd0, 64'h0, 2);
    release_op(1, 64'h0);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 33);
    release_op(0, 64'h00000000_80000000);
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, 64'h00000000_FFFFFFFF, 33);
    release_op(0, 64'h00000000_FFFFFFFF);

    // Annul on the 10th ON cycle
    @(negedge clk);
    signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    chk("annul_busy_before", 64'(busy_o), 64'd1);
    @(negedge clk);
    annul_i = 1'b1;
    #1;
    chk("annul_stall", 64'(stallreq_o), 64'd0);
    @(posedge clk);
    #1;
    chk_idle_outputs("annul");
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("annul_no_ready", 64'(ready_o), 64'd0);
    end
    issue(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);
    release_op(0, 64'h00000000_00000003);

    // Reset during ON
    @(negedge clk);
    signed_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd4; start_i = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_on_stall_comb", 64'(stallreq_o), 64'd1);
    @(posedge clk);
    #1;
    chk_idle_outputs("rst_on");
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    issue(1'b0, 32'd20, 32'd6, 64'h00000002_00000003, 33);

    // Reset during END
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_idle_outputs("rst_end");
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    issue(1'b0, 32'd20, 32'd6, 64'h00000002_00000003, 33);
    release_op(0, 64'h00000002_00000003);

    for (int n = 0; n < 24; n++) begin
      sg = 1'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = corners[$urandom_range(0, 5)];
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      exp = ref_div(sg, a, b);
      issue(sg, a, b, exp, (b == 32'd0) ? 2 : 33);
      release_op($urandom_range(0, 2), exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
